// File: rtl/ext_ram_arbiter.sv
// Two-port arbiter for the 4-bit serial external RAM: CMD, 4 address nibbles, latency, 4 data nibbles.
// Define EXT_RAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ext_ram_arbiter #(
  parameter int RAM_LATENCY = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [3:0]  addr_out,
  input  logic [3:0]  data_in,
  output logic [2:0]  dbg_state
);

  // Handshake: a requester raises reqN with addrN stable and holds both until ackN, a
  // one-cycle pulse with rdata valid in that cycle; a req still high afterwards is a new request.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] CMD_READ  = 4'h1;
  localparam logic [3:0] WAIT_LOAD = 4'(RAM_LATENCY - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  beat;
  logic [1:0]  beat_nx;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_nx;
  logic        grant;
  logic        grant_nx;
  logic [15:0] addr_sh;
  logic [15:0] addr_sh_nx;
  logic [15:0] shreg;
  logic [15:0] shreg_nx;
  logic [3:0]  addr_out_nx;
  logic        turn;
  logic        take;
  logic        pick;

  // The IDLE cycle right after DONE is a turnaround: requests stay pending and are granted
  // one cycle later, giving the 12+RAM_LATENCY back-to-back period.
  assign take = (state == S_IDLE) && !turn && (req0 || req1);

`ifdef EXT_RAM_ARB_RR_EN
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= pick;
    end
  end

  assign pick = (req0 && req1) ? !last : req1;
`else
  assign pick = !req0;
`endif

  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    wcnt_nx     = wcnt;
    grant_nx    = grant;
    addr_sh_nx  = addr_sh;
    shreg_nx    = shreg;
    addr_out_nx = 4'h0;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_nx   = S_CMD;
          grant_nx   = pick;
          addr_sh_nx = pick ? addr1 : addr0;
        end
      end
      S_CMD: begin
        state_nx = S_ADDR;
        beat_nx  = 2'd0;
      end
      S_ADDR: begin
        if (beat == 2'd3) begin
          state_nx = S_WAIT;
          wcnt_nx  = WAIT_LOAD;
        end else begin
          beat_nx = beat + 2'd1;
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nx = S_DATA;
          beat_nx  = 2'd0;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      S_DATA: begin
        shreg_nx = {data_in, shreg[15:4]};
        if (beat == 2'd3) begin
          state_nx = S_DONE;
        end else begin
          beat_nx = beat + 2'd1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    if (state_nx == S_CMD) begin
      addr_out_nx = CMD_READ;
    end else if (state_nx == S_ADDR) begin
      addr_out_nx = addr_sh[3:0];
      addr_sh_nx  = {4'h0, addr_sh[15:4]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat     <= 2'd0;
      wcnt     <= 4'd0;
      grant    <= 1'b0;
      addr_sh  <= 16'h0000;
      shreg    <= 16'h0000;
      turn     <= 1'b0;
      addr_out <= 4'h0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= 16'h0000;
    end else begin
      state    <= state_nx;
      beat     <= beat_nx;
      wcnt     <= wcnt_nx;
      grant    <= grant_nx;
      addr_sh  <= addr_sh_nx;
      shreg    <= shreg_nx;
      turn     <= (state == S_DONE);
      addr_out <= addr_out_nx;
      busy     <= (state_nx != S_IDLE);
      ack0     <= (state_nx == S_DONE) && !grant_nx;
      ack1     <= (state_nx == S_DONE) && grant_nx;
      if (state_nx == S_DONE) begin
        rdata <= shreg_nx;
      end
    end
  end

  assign dbg_state = state;

endmodule
